// File: rtl/sd_fifo_mc.sv
// Multi-channel srdy/drdy FIFO: nch queues share one memory, round-robin drained into one output register.
// Optional per-channel flush input when SD_FIFO_MC_FLUSH_EN is defined.
module sd_fifo_mc #(
    parameter int width = 8,
    parameter int depth = 16,
    parameter int nch   = 4,
    parameter int asz   = $clog2(depth),
    parameter int csz   = $clog2(nch)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     c_srdy,
    output logic                     c_drdy,
    input  logic [csz-1:0]           c_chan,
    input  logic [width-1:0]         c_data,
`ifdef SD_FIFO_MC_FLUSH_EN
    input  logic [nch-1:0]           flush,
`endif
    output logic                     p_srdy,
    input  logic                     p_drdy,
    output logic [csz-1:0]           p_chan,
    output logic [width-1:0]         p_data,
    output logic [nch*(asz+1)-1:0]   usage
);

    localparam int AW = $clog2(nch * depth);
    localparam int CW = asz + 1;
    localparam logic [asz-1:0] PTR_LAST  = asz'(depth - 1);
    localparam logic [CW-1:0]  CNT_FULL  = CW'(depth);
    localparam logic [csz-1:0] LAST_INIT = csz'(nch - 1);

    logic [width-1:0] mem [nch*depth];

    logic [asz-1:0]   wrptr_q [nch];
    logic [asz-1:0]   wrptr_d [nch];
    logic [asz-1:0]   rdptr_q [nch];
    logic [asz-1:0]   rdptr_d [nch];
    logic [CW-1:0]    count_q [nch];
    logic [CW-1:0]    count_d [nch];
    logic [csz-1:0]   last_q, last_d;
    logic             p_srdy_q, p_srdy_d;
    logic [csz-1:0]   p_chan_q, p_chan_d;
    logic [width-1:0] p_data_q, p_data_d;

    logic [nch-1:0]   flush_v;
    logic             wr_en;
    logic             issue;
    logic             any_ready;
    logic [csz-1:0]   grant;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;

`ifdef SD_FIFO_MC_FLUSH_EN
    assign flush_v = flush;
`else
    assign flush_v = '0;
`endif

    function automatic logic [asz-1:0] ptr_inc(input logic [asz-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Illegal channel ids never match a k, so c_drdy stays low for them.
    always_comb begin
        c_drdy = 1'b0;
        for (int k = 0; k < nch; k++) begin
            if (c_chan == csz'(k)) begin
                c_drdy = (count_q[k] != CNT_FULL) && !flush_v[k];
            end
        end
    end

    assign wr_en   = c_srdy & c_drdy;
    assign wr_addr = AW'(c_chan) * AW'(depth) + AW'(wrptr_q[c_chan]);
    assign rd_addr = AW'(grant) * AW'(depth) + AW'(rdptr_q[grant]);

    always_comb begin : arb
        int             j;
        logic [csz-1:0] idx;
        j         = 0;
        idx       = '0;
        any_ready = 1'b0;
        grant     = last_q;
        for (int i = 1; i <= nch; i++) begin
            j   = (int'(last_q) + i) % nch;
            idx = csz'(j);
            if (!any_ready && (count_q[idx] != '0) && !flush_v[idx]) begin
                any_ready = 1'b1;
                grant     = idx;
            end
        end
        issue = any_ready && (!p_srdy_q || p_drdy);
    end

    always_comb begin
        for (int k = 0; k < nch; k++) begin
            logic inc, dec;
            inc        = wr_en && (c_chan == csz'(k));
            dec        = issue && (grant == csz'(k));
            wrptr_d[k] = inc ? ptr_inc(wrptr_q[k]) : wrptr_q[k];
            rdptr_d[k] = dec ? ptr_inc(rdptr_q[k]) : rdptr_q[k];
            count_d[k] = count_q[k];
            if (inc && !dec) begin
                count_d[k] = count_q[k] + 1'b1;
            end else if (!inc && dec) begin
                count_d[k] = count_q[k] - 1'b1;
            end
            if (flush_v[k]) begin
                wrptr_d[k] = '0;
                rdptr_d[k] = '0;
                count_d[k] = '0;
            end
        end
    end

    always_comb begin
        p_srdy_d = p_srdy_q;
        p_chan_d = p_chan_q;
        p_data_d = p_data_q;
        last_d   = last_q;
        if (issue) begin
            p_srdy_d = 1'b1;
            p_chan_d = grant;
            p_data_d = mem[rd_addr];
            last_d   = grant;
        end else if (p_drdy) begin
            p_srdy_d = 1'b0;
        end
    end

    always_comb begin
        usage = '0;
        for (int k = 0; k < nch; k++) begin
            usage[k*CW +: CW] = count_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= c_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < nch; k++) begin
                wrptr_q[k] <= '0;
                rdptr_q[k] <= '0;
                count_q[k] <= '0;
            end
            last_q   <= LAST_INIT;
            p_srdy_q <= 1'b0;
            p_chan_q <= '0;
            p_data_q <= '0;
        end else begin
            for (int k = 0; k < nch; k++) begin
                wrptr_q[k] <= wrptr_d[k];
                rdptr_q[k] <= rdptr_d[k];
                count_q[k] <= count_d[k];
            end
            last_q   <= last_d;
            p_srdy_q <= p_srdy_d;
            p_chan_q <= p_chan_d;
            p_data_q <= p_data_d;
        end
    end

    assign p_srdy = p_srdy_q;
    assign p_chan = p_chan_q;
    assign p_data = p_data_q;

endmodule
